// File: rtl/onewire_master_bit_if.sv
// Bit-command handshake between the byte/ROM sequencer and the 1-wire bit master.
// Latency: n/a (wires only).  Backpressure: cmd_ready gates cmd_valid; rsp has no ready.
interface onewire_master_bit_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic       cmd_ovd;
    logic       rsp_valid;
    logic       rsp_data;

    modport master (
        output cmd_valid, cmd, cmd_ovd,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd, cmd_ovd,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/onewire_master_bit.sv
// 1-wire bit-layer master: reset/presence, write-0/1 and read slots; ONEWIRE_OVD_EN adds overdrive timing.
// Latency: one slot (TE ticks) from acceptance to a single-cycle rsp_valid.
// Backpressure: cmd_ready low for the whole slot, high again in the rsp_valid cycle; no queueing.
module onewire_master_bit #(
    parameter int unsigned CDR   = 4,
    parameter int unsigned CDR_O = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    onewire_master_bit_if.slave  bus,
    output logic                 owr_oe,
    input  logic                 owr_i
);

    typedef enum logic [1:0] {IDLE, LOW, REL} state_t;

    localparam logic [1:0] CMD_RST = 2'd0;
    localparam logic [1:0] CMD_WR0 = 2'd1;

    typedef struct packed {
        logic [15:0] tl;
        logic [15:0] ts;
        logic [15:0] te;
    } slot_t;

    if (CDR < 1 || CDR > 255 || CDR_O < 1 || CDR_O > 255) begin : g_bad_param
        $error("onewire_master_bit: CDR and CDR_O must be in 1..255");
    end

    localparam logic [7:0] PRE_N = 8'(CDR - 1);

    state_t      state, state_nxt;
    logic [1:0]  cmd_q, cmd_nxt;
    logic [7:0]  pre, pre_nxt, pre_top;
    logic [15:0] t, t_nxt;
    logic        samp, samp_nxt;
    logic        oe_nxt;
    logic        rsp_valid_q, rsp_valid_nxt;
    logic        rsp_data_q, rsp_data_nxt;
    logic        sync1, sync2;
    logic        tick;
    slot_t       tim;

`ifdef ONEWIRE_OVD_EN
    localparam logic [7:0] PRE_O = 8'(CDR_O - 1);
    logic ovd_q, ovd_nxt;

    function automatic slot_t slot_time(input logic [1:0] c, input logic ovd);
        slot_t s;
        if (ovd) begin
            case (c)
                CMD_RST: s = '{tl: 16'd560, ts: 16'd624, te: 16'd768};
                CMD_WR0: s = '{tl: 16'd60,  ts: 16'd16,  te: 16'd80};
                default: s = '{tl: 16'd8,   ts: 16'd16,  te: 16'd80};
            endcase
        end else begin
            case (c)
                CMD_RST: s = '{tl: 16'd480, ts: 16'd550, te: 16'd960};
                CMD_WR0: s = '{tl: 16'd60,  ts: 16'd15,  te: 16'd70};
                default: s = '{tl: 16'd6,   ts: 16'd15,  te: 16'd70};
            endcase
        end
        return s;
    endfunction

    assign tim     = slot_time(cmd_q, ovd_q);
    assign pre_top = ovd_q ? PRE_O : PRE_N;
`else
    function automatic slot_t slot_time(input logic [1:0] c);
        slot_t s;
        case (c)
            CMD_RST: s = '{tl: 16'd480, ts: 16'd550, te: 16'd960};
            CMD_WR0: s = '{tl: 16'd60,  ts: 16'd15,  te: 16'd70};
            default: s = '{tl: 16'd6,   ts: 16'd15,  te: 16'd70};
        endcase
        return s;
    endfunction

    assign tim     = slot_time(cmd_q);
    assign pre_top = PRE_N;
`endif

    assign tick          = (pre == pre_top);
    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Line level is asynchronous to clk; only sync2 is ever sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= owr_i;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_q       <= 2'd0;
            pre         <= 8'd0;
            t           <= 16'd0;
            samp        <= 1'b0;
            owr_oe      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_q       <= cmd_nxt;
            pre         <= pre_nxt;
            t           <= t_nxt;
            samp        <= samp_nxt;
            owr_oe      <= oe_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_data_q  <= rsp_data_nxt;
        end
    end

`ifdef ONEWIRE_OVD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovd_q <= 1'b0;
        else        ovd_q <= ovd_nxt;
    end
`endif

    // Thresholds are compared against t_nxt so each event lands on the edge where t reaches it.
    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd_q;
        pre_nxt       = pre;
        t_nxt         = t;
        samp_nxt      = samp;
        oe_nxt        = owr_oe;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data_q;
`ifdef ONEWIRE_OVD_EN
        ovd_nxt       = ovd_q;
`endif
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = LOW;
                    cmd_nxt   = bus.cmd;
                    pre_nxt   = 8'd0;
                    t_nxt     = 16'd0;
                    oe_nxt    = 1'b1;
`ifdef ONEWIRE_OVD_EN
                    ovd_nxt   = bus.cmd_ovd;
`endif
                end
            end
            LOW, REL: begin
                pre_nxt = tick ? 8'd0 : pre + 8'd1;
                if (tick) t_nxt = t + 16'd1;
                if (tick && t_nxt == tim.ts) samp_nxt = sync2;
                if (state == LOW) begin
                    if (tick && t_nxt == tim.tl) begin
                        oe_nxt    = 1'b0;
                        state_nxt = REL;
                    end
                end else if (tick && t_nxt == tim.te) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = (cmd_q == CMD_RST) ? ~samp_nxt : samp_nxt;
                end
            end
            default: begin
                state_nxt = IDLE;
                oe_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_onewire_master_bit.sv
// Scoreboarded bench for onewire_master_bit: directed slots, slave pull-down model, async abort.
module tb_onewire_master_bit;

    localparam int CDR   = 4;
    localparam int CDR_O = 1;

    typedef struct {
        logic  data;
        int    lat;
        int    oe;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic owr_oe;
    logic owr_line;
    logic slave_pull = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   oe_cnt = 0;

    exp_t exp_q[$];
    int   acc_q[$];

    onewire_master_bit_if bus ();

    onewire_master_bit #(.CDR(CDR), .CDR_O(CDR_O)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .owr_oe (owr_oe),
        .owr_i  (owr_line)
    );

    assign owr_line = ~(owr_oe | slave_pull);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per rsp_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst_n) begin
            oe_cnt = 0;
        end else begin
            if (owr_oe) oe_cnt++;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk({e.nm, "_data"}, int'(bus.rsp_data), int'(e.data));
                    chk({e.nm, "_latency"}, cyc - a, e.lat);
                    chk({e.nm, "_oe_cycles"}, oe_cnt, e.oe);
                end
                oe_cnt = 0;
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic ovd, input logic d,
                        input int lat, input int oe, input string nm, input bit track);
        bit done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                bus.cmd_valid = 1'b1;
                bus.cmd       = c;
                bus.cmd_ovd   = ovd;
                if (track) begin
                    exp_q.push_back('{data: d, lat: lat, oe: oe, nm: nm});
                    acc_q.push_back(cyc);
                end
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
                bus.cmd       = 2'($urandom_range(0, 3));
                bus.cmd_ovd   = 1'($urandom_range(0, 1));
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got no cmd_ready, expected acceptance", nm);
        end
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_rsp_timeout: got %0d pending, expected 0", nm, exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'd0;
        bus.cmd_ovd   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data",  int'(bus.rsp_data), 0);
        chk("rst_owr_oe",    int'(owr_oe), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset with slave presence pulse 500..600 us after acceptance.
        send(2'd0, 1'b0, 1'b1, 3841, 1920, "rst_presence", 1'b1);
        repeat (1999) @(posedge clk);
        slave_pull = 1'b1;
        repeat (400) @(posedge clk);
        slave_pull = 1'b0;
        wait_idle("rst_presence");

        send(2'd0, 1'b0, 1'b0, 3841, 1920, "rst_no_slave", 1'b1);
        wait_idle("rst_no_slave");

        // Back-to-back: WR1 accepted in the WR0 rsp_valid cycle.
        send(2'd1, 1'b0, 1'b0, 281, 240, "wr0", 1'b1);
        send(2'd2, 1'b0, 1'b1, 281, 24,  "wr1", 1'b1);
        wait_idle("wr_pair");

        slave_pull = 1'b1;
        send(2'd3, 1'b0, 1'b0, 281, 24, "rd_slave0", 1'b1);
        wait_idle("rd_slave0");
        slave_pull = 1'b0;

        send(2'd3, 1'b0, 1'b1, 281, 24, "rd_slave1", 1'b1);
        wait_idle("rd_slave1");

        // Slave holds the line low only around tick 15 (cycles 40..64).
        send(2'd3, 1'b0, 1'b0, 281, 24, "rd_window", 1'b1);
        repeat (39) @(posedge clk);
        slave_pull = 1'b1;
        repeat (24) @(posedge clk);
        slave_pull = 1'b0;
        wait_idle("rd_window");

        // Abort a WR0 at tick 30 with an asynchronous reset pulse.
        send(2'd1, 1'b0, 1'b0, 0, 0, "wr0_abort", 1'b0);
        repeat (120) @(posedge clk);
        #1;
        chk("abort_oe_before", int'(owr_oe), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_oe_async", int'(owr_oe), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_cmd_ready", int'(bus.cmd_ready), 1);
        repeat (400) @(negedge clk);

        send(2'd2, 1'b0, 1'b1, 281, 24, "wr1_after_abort", 1'b1);
        wait_idle("wr1_after_abort");

`ifdef ONEWIRE_OVD_EN
        send(2'd0, 1'b1, 1'b0, 769, 560, "rst_ovd", 1'b1);
        wait_idle("rst_ovd");
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
